// File: rtl/inta_pkg.sv
// Shared types and constants for the INTA sequencer.
package inta_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } inta_state_t;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;
    localparam int         PULSES_8086 = 2;
    localparam int         PULSES_8080 = 3;

endpackage

// File: rtl/inta_pulse_timer.sv
// Loadable down-counter; terminal_count marks the final cycle of a timed phase.
module inta_pulse_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             terminal_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Saturates at zero so an idle timer never wraps.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal_count = (count_q == WIDTH'(1));

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge initiator: drives timed INTA pulse trains and captures the PIC response.
// Optional opcode check on the 8080 first byte is enabled by defining INTA_OPCODE_CHECK_EN.
module inta_sequencer
    import inta_pkg::*;
#(
    parameter int PULSE_WIDTH = 4,
    parameter int GAP_WIDTH   = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        mode_8086,
    input  logic        interrupt,
    input  logic [7:0]  data_bus_in,
    output logic        interrupt_acknowledge_n,
    output logic        busy,
    output logic        vector_valid,
    output logic [7:0]  vector,
    output logic [15:0] call_address,
    output logic        protocol_error
);

    localparam int MAX_WIDTH = (PULSE_WIDTH > GAP_WIDTH) ? PULSE_WIDTH : GAP_WIDTH;
    localparam int CNT_W     = $clog2(MAX_WIDTH + 1);
    localparam logic [CNT_W-1:0] PW_LOAD = CNT_W'(PULSE_WIDTH);
    localparam logic [CNT_W-1:0] GW_LOAD = CNT_W'(GAP_WIDTH);

    inta_state_t state_q, state_d;
    logic        mode_q, mode_d;
    logic [1:0]  index_q, index_d;
    logic [7:0]  byte1_q, byte1_d;
    logic [7:0]  vector_q, vector_d;
    logic [15:0] call_q, call_d;
    logic        inta_n_q, inta_n_d;

    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_tc;
    logic             last_pulse;
    logic [7:0]       byte1_now;

`ifdef INTA_OPCODE_CHECK_EN
    logic [7:0] byte0_q, byte0_d;
    logic       perr_q, perr_d;
`endif

    inta_pulse_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clock          (clock),
        .reset_n        (reset_n),
        .load           (timer_load),
        .load_value     (timer_value),
        .terminal_count (timer_tc)
    );

    assign last_pulse = mode_q ? (index_q == 2'(PULSES_8086 - 1))
                               : (index_q == 2'(PULSES_8080 - 1));
    // Byte1 is still on the bus when it is the final sample of an 8086 train.
    assign byte1_now  = (index_q == 2'd1) ? data_bus_in : byte1_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        index_d     = index_q;
        byte1_d     = byte1_q;
        vector_d    = vector_q;
        call_d      = call_q;
        timer_load  = 1'b0;
        timer_value = PW_LOAD;
`ifdef INTA_OPCODE_CHECK_EN
        byte0_d     = byte0_q;
        perr_d      = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (interrupt && enable) begin
                    state_d    = PULSE;
                    mode_d     = mode_8086;
                    index_d    = 2'd0;
                    timer_load = 1'b1;
`ifdef INTA_OPCODE_CHECK_EN
                    perr_d     = 1'b0;
`endif
                end
            end
            PULSE: begin
                if (timer_tc) begin
                    if (index_q == 2'd1) begin
                        byte1_d = data_bus_in;
                    end
`ifdef INTA_OPCODE_CHECK_EN
                    if (index_q == 2'd0) begin
                        byte0_d = data_bus_in;
                    end
`endif
                    if (last_pulse) begin
                        state_d  = DONE;
                        vector_d = byte1_now;
                        call_d   = mode_q ? 16'h0000 : {data_bus_in, byte1_now};
`ifdef INTA_OPCODE_CHECK_EN
                        if (!mode_q && (byte0_q != CALL_OPCODE)) begin
                            perr_d = 1'b1;
                        end
`endif
                    end else begin
                        state_d     = GAP;
                        timer_load  = 1'b1;
                        timer_value = GW_LOAD;
                    end
                end
            end
            GAP: begin
                if (timer_tc) begin
                    state_d    = PULSE;
                    index_d    = index_q + 2'd1;
                    timer_load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered INTA: low exactly while the state register holds PULSE.
        inta_n_d = (state_d != PULSE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            index_q  <= 2'd0;
            byte1_q  <= 8'h00;
            vector_q <= 8'h00;
            call_q   <= 16'h0000;
            inta_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            index_q  <= index_d;
            byte1_q  <= byte1_d;
            vector_q <= vector_d;
            call_q   <= call_d;
            inta_n_q <= inta_n_d;
        end
    end

`ifdef INTA_OPCODE_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte0_q <= 8'h00;
            perr_q  <= 1'b0;
        end else begin
            byte0_q <= byte0_d;
            perr_q  <= perr_d;
        end
    end
    assign protocol_error = perr_q;
`else
    assign protocol_error = 1'b0;
`endif

    assign interrupt_acknowledge_n = inta_n_q;
    assign busy                    = (state_q != IDLE);
    assign vector_valid            = (state_q == DONE);
    assign vector                  = vector_q;
    assign call_address            = call_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: directed sequences, decoupled valid-strobe monitor.
module tb_inta_sequencer;

    localparam int PW = 4;
    localparam int GW = 2;
    localparam int LAT_8086 = 1 + 2 * PW + GW;
    localparam int LAT_8080 = 1 + 3 * PW + 2 * GW;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        mode_8086;
    logic        interrupt;
    logic [7:0]  data_bus_in;
    logic        interrupt_acknowledge_n;
    logic        busy;
    logic        vector_valid;
    logic [7:0]  vector;
    logic [15:0] call_address;
    logic        protocol_error;

    // Entry layout: {valid_cycle[15:0], pulses[3:0], perr, call[15:0], vector[7:0]}
    logic [44:0] exp_q[$];
    logic [7:0]  bus_bytes [0:2];
    int          cyc;
    int          checks;
    int          errors;

    inta_sequencer #(
        .PULSE_WIDTH (PW),
        .GAP_WIDTH   (GW)
    ) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .enable                  (enable),
        .mode_8086               (mode_8086),
        .interrupt               (interrupt),
        .data_bus_in             (data_bus_in),
        .interrupt_acknowledge_n (interrupt_acknowledge_n),
        .busy                    (busy),
        .vector_valid            (vector_valid),
        .vector                  (vector),
        .call_address            (call_address),
        .protocol_error          (protocol_error)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- PIC bus model ----------------
    initial begin
        int  pidx;
        logic prev_n;
        pidx        = 0;
        prev_n      = 1'b1;
        data_bus_in = 8'hEE;
        forever begin
            @(negedge clock);
            if (!busy) pidx = 0;
            else if (!prev_n && interrupt_acknowledge_n) pidx = pidx + 1;
            if (!interrupt_acknowledge_n && pidx < 3) data_bus_in = bus_bytes[pidx];
            else data_bus_in = 8'hEE;
            prev_n = interrupt_acknowledge_n;
        end
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int          low_cnt;
        int          pulse_cnt;
        logic [44:0] e;
        low_cnt   = 0;
        pulse_cnt = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                low_cnt   = 0;
                pulse_cnt = 0;
            end else begin
                if (!interrupt_acknowledge_n) begin
                    low_cnt = low_cnt + 1;
                end else if (low_cnt != 0) begin
                    check("pulse_width", low_cnt, PW);
                    pulse_cnt = pulse_cnt + 1;
                    low_cnt   = 0;
                end
                if (vector_valid) begin
                    if (exp_q.size() == 0) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("vector", {24'h0, vector}, {24'h0, e[7:0]});
                        check("call_address", {16'h0, call_address}, {16'h0, e[23:8]});
                        check("protocol_error", {31'h0, protocol_error}, {31'h0, e[24]});
                        check("pulse_count", pulse_cnt, {28'h0, e[28:25]});
                        check("valid_cycle", {16'h0, cyc[15:0]}, {16'h0, e[44:29]});
                    end
                    pulse_cnt = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [44:0] make_exp(input logic m, input logic [7:0] b0,
                                             input logic [7:0] b1, input logic [7:0] b2,
                                             input int vcyc);
        logic        perr;
        logic [15:0] call;
        logic [3:0]  np;
        perr = 1'b0;
`ifdef INTA_OPCODE_CHECK_EN
        if (!m && b0 != 8'hCD) perr = 1'b1;
`else
        if (b0 == b0) perr = 1'b0;
`endif
        call = m ? 16'h0000 : {b2, b1};
        np   = m ? 4'd2 : 4'd3;
        return {vcyc[15:0], np, perr, call, b1};
    endfunction

    // Single-cycle request; expectation is queued before the DUT can respond.
    task automatic start_seq(input logic m, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
        @(negedge clock);
        bus_bytes[0] = b0;
        bus_bytes[1] = b1;
        bus_bytes[2] = b2;
        mode_8086    = m;
        enable       = 1'b1;
        interrupt    = 1'b1;
        exp_q.push_back(make_exp(m, b0, b1, b2, cyc + (m ? LAT_8086 : LAT_8080)));
        @(negedge clock);
        interrupt = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        check(name, {31'h0, done}, 32'h1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int req;
        int act;
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        enable       = 1'b0;
        mode_8086    = 1'b1;
        interrupt    = 1'b0;
        bus_bytes[0] = 8'h00;
        bus_bytes[1] = 8'h00;
        bus_bytes[2] = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_inta_n", {31'h0, interrupt_acknowledge_n}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_valid", {31'h0, vector_valid}, 32'h0);
        check("rst_vector", {24'h0, vector}, 32'h0);
        check("rst_call", {16'h0, call_address}, 32'h0);
        check("rst_perr", {31'h0, protocol_error}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // 8086 and 8080 basic sequences
        start_seq(1'b1, 8'hFF, 8'h48, 8'h00);
        wait_idle("idle_8086");
        start_seq(1'b0, 8'hCD, 8'h20, 8'h3F);
        wait_idle("idle_8080");
        repeat (3) @(negedge clock);
        check("hold_vector", {24'h0, vector}, 32'h20);
        check("hold_call", {16'h0, call_address}, 32'h3F20);

        // Bad opcode, then a good one clears the sticky flag at start
        start_seq(1'b0, 8'h00, 8'h11, 8'h22);
        wait_idle("idle_badop");
        start_seq(1'b0, 8'hCD, 8'h9A, 8'hBC);
        wait_idle("idle_goodop");

        // Request blocked while enable is low
        @(negedge clock);
        enable    = 1'b0;
        interrupt = 1'b1;
        act       = 0;
        repeat (20) begin
            @(negedge clock);
            if (!interrupt_acknowledge_n || busy) act = act + 1;
        end
        check("enable_block", act, 0);
        interrupt = 1'b0;
        @(negedge clock);

        // Held request: second train starts after exactly one IDLE cycle
        bus_bytes[0] = 8'hFF;
        bus_bytes[1] = 8'h48;
        bus_bytes[2] = 8'h00;
        mode_8086    = 1'b1;
        enable       = 1'b1;
        interrupt    = 1'b1;
        req          = cyc;
        exp_q.push_back(make_exp(1'b1, 8'hFF, 8'h48, 8'h00, req + LAT_8086));
        exp_q.push_back(make_exp(1'b1, 8'hFF, 8'h48, 8'h00, req + 2 * LAT_8086 + 1));
        repeat (15) @(negedge clock);
        interrupt = 1'b0;
        wait_idle("idle_held");

        // Mode and enable changes mid-sequence follow the latched mode
        start_seq(1'b0, 8'hCD, 8'h55, 8'h66);
        repeat (3) @(negedge clock);
        mode_8086 = 1'b1;
        enable    = 1'b0;
        wait_idle("idle_mid_8080");
        start_seq(1'b1, 8'h00, 8'h77, 8'h00);
        repeat (3) @(negedge clock);
        mode_8086 = 1'b0;
        wait_idle("idle_mid_8086");

        // Asynchronous reset in the middle of the first pulse
        start_seq(1'b1, 8'hFF, 8'h48, 8'h00);
        check("pre_reset_low", {31'h0, interrupt_acknowledge_n}, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_inta_n", {31'h0, interrupt_acknowledge_n}, 32'h1);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_vector", {24'h0, vector}, 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        start_seq(1'b1, 8'h00, 8'h5A, 8'h00);
        wait_idle("idle_after_reset");

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
